// File: rtl/b205_fe_sequencer.sv
// b205_fe_sequencer: half-duplex RF front-end sequencer for antenna switches and TX PA enable.
// Ports:
//   clk, reset              radio clock, asynchronous active-high reset
//   tx_req, rx_req          activity requests (levels), TX has priority
//   cfg_rx_port             0 = receive on TX/RX, 1 = receive on RX2 (sampled on RX_SW entry)
//   cfg_sw_dly              switch settle dwell, cycles
//   cfg_pa_on_dly           PA warm-up dwell, cycles
//   cfg_pa_off_dly          PA decay dwell before the switch may move, cycles
//   tx_grant, rx_grant      path ready indications
//   fe_sel_*                antenna switch selects
//   txdrv_pwen              TX PA enable
//   state                   current state encoding for debug readback
//   tx_bursts               completed TX_ON exits, wrapping
module b205_fe_sequencer #(
    parameter int DLY_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_req,
    input  logic             rx_req,
    input  logic             cfg_rx_port,
    input  logic [DLY_W-1:0] cfg_sw_dly,
    input  logic [DLY_W-1:0] cfg_pa_on_dly,
    input  logic [DLY_W-1:0] cfg_pa_off_dly,
    output logic             tx_grant,
    output logic             rx_grant,
    output logic             fe_sel_trx_tx,
    output logic             fe_sel_trx_rx,
    output logic             fe_sel_rx_trx,
    output logic             fe_sel_rx_rx2,
    output logic             txdrv_pwen,
    output logic [2:0]       state,
    output logic [15:0]      tx_bursts
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RX_SW  = 3'd1,
        RX_ON  = 3'd2,
        TX_SW  = 3'd3,
        TX_PA  = 3'd4,
        TX_ON  = 3'd5,
        TX_OFF = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [15:0]      bursts_q, bursts_d;
    logic             port_q, port_d;
    logic             done, entry, rx_sel;

    assign done = cnt_q == '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = tx_req ? TX_SW : rx_req ? RX_SW : IDLE;
            RX_SW:   state_d = tx_req ? TX_SW : !rx_req ? IDLE : done ? RX_ON : RX_SW;
            RX_ON:   state_d = tx_req ? TX_SW : !rx_req ? IDLE : RX_ON;
            TX_SW:   state_d = !tx_req ? IDLE : done ? TX_PA : TX_SW;
            TX_PA:   state_d = !tx_req ? TX_OFF : done ? TX_ON : TX_PA;
            TX_ON:   state_d = !tx_req ? TX_OFF : TX_ON;
            // PA decay must complete regardless of requests before the switch moves
            TX_OFF:  state_d = !done ? TX_OFF : tx_req ? TX_SW : rx_req ? RX_SW : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Delays are captured only when a dwell state is entered (including re-entry from another state)
    assign entry    = state_d != state_q;
    assign cnt_d    = entry ? (state_d inside {RX_SW, TX_SW} ? cfg_sw_dly :
                               state_d == TX_PA ? cfg_pa_on_dly :
                               state_d == TX_OFF ? cfg_pa_off_dly : '0)
                            : done ? '0 : cnt_q - DLY_W'(1);
    assign port_d   = (entry && state_d == RX_SW) ? cfg_rx_port : port_q;
    assign bursts_d = (state_q == TX_ON && state_d == TX_OFF) ? bursts_q + 16'd1 : bursts_q;
    assign rx_sel   = state_d == RX_SW || state_d == RX_ON;

    // Outputs are decoded from the next state so they change on the same edge as state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            port_q        <= 1'b0;
            bursts_q      <= '0;
            tx_grant      <= 1'b0;
            rx_grant      <= 1'b0;
            fe_sel_trx_tx <= 1'b0;
            fe_sel_trx_rx <= 1'b0;
            fe_sel_rx_trx <= 1'b0;
            fe_sel_rx_rx2 <= 1'b0;
            txdrv_pwen    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            port_q        <= port_d;
            bursts_q      <= bursts_d;
            tx_grant      <= state_d == TX_ON;
            rx_grant      <= state_d == RX_ON;
            fe_sel_trx_tx <= state_d inside {TX_SW, TX_PA, TX_ON, TX_OFF};
            fe_sel_trx_rx <= rx_sel && !port_d;
            fe_sel_rx_trx <= rx_sel && !port_d;
            fe_sel_rx_rx2 <= rx_sel && port_d;
            txdrv_pwen    <= state_d inside {TX_PA, TX_ON};
        end
    end

    assign state     = state_q;
    assign tx_bursts = bursts_q;
endmodule

// File: doc/b205_fe_sequencer.md
# b205_fe_sequencer

RF front-end sequencer for the B205 radio path. Turns the radio's transmit and receive activity requests into a safe, timed sequence on the antenna switches (cFE_SEL_*) and the TX PA enable (cTXDRV_PWEN). It guarantees the PA is never enabled before the TRX switch has settled, and that the switch never moves while the PA is on. It sits in the radio_clk domain between the radio core's activity flags and the IOB-registered front-end pins.

## Interface

Parameters:
- DLY_W, 16, width of all delay configuration inputs and the internal dwell counter.

Ports:
- clk  in  1  radio clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs low.
- tx_req  in  1  radio requests transmit; level, held for the whole burst.
- rx_req  in  1  radio requests receive; level.
- cfg_rx_port  in  1  0 = receive on TX/RX port, 1 = receive on RX2; sampled on entry to RX_SW.
- cfg_sw_dly  in  DLY_W  switch settle time, cycles.
- cfg_pa_on_dly  in  DLY_W  PA warm-up time after pwen rises, cycles.
- cfg_pa_off_dly  in  DLY_W  PA decay time before the switch may move, cycles.
- tx_grant  out  1  TX path ready; the radio may drive samples.
- rx_grant  out  1  RX path ready; samples are valid.
- fe_sel_trx_tx  out  1  TX/RX port to transmitter.
- fe_sel_trx_rx  out  1  TX/RX port to receiver.
- fe_sel_rx_trx  out  1  receiver fed from TX/RX port.
- fe_sel_rx_rx2  out  1  receiver fed from RX2 port.
- txdrv_pwen  out  1  TX PA enable.
- state  out  3  current state encoding, for debug readback.
- tx_bursts  out  16  count of completed TX_ON exits; wraps 0xFFFF -> 0.

## Operation

Half-duplex. TX has priority over RX. States, with their encodings:
- IDLE (0). All outputs 0.
- RX_SW (1). Receive selects driven per the latched port, grant 0.
  - Latched port 0: fe_sel_trx_rx = fe_sel_rx_trx = 1.
  - Latched port 1: fe_sel_rx_rx2 = 1.
- RX_ON (2). Same selects as RX_SW, rx_grant = 1.
- TX_SW (3). fe_sel_trx_tx = 1, pwen 0.
- TX_PA (4). fe_sel_trx_tx = 1, pwen 1.
- TX_ON (5). fe_sel_trx_tx = 1, pwen 1, tx_grant = 1.
- TX_OFF (6). fe_sel_trx_tx = 1, pwen 0.

Transitions (evaluated every cycle; "done" means the dwell counter equals 0):
- IDLE: tx_req -> TX_SW; else rx_req -> RX_SW.
- RX_SW: tx_req -> TX_SW; else !rx_req -> IDLE; else done -> RX_ON.
- RX_ON: tx_req -> TX_SW; else !rx_req -> IDLE.
- TX_SW: !tx_req -> IDLE (the PA was never on); else done -> TX_PA.
- TX_PA: !tx_req -> TX_OFF; else done -> TX_ON.
- TX_ON: !tx_req -> TX_OFF, and tx_bursts increments.
- TX_OFF: always runs to done, ignoring all requests; then tx_req -> TX_SW, else rx_req -> RX_SW, else IDLE.

Dwell counter:
- Loaded on entry to RX_SW and TX_SW (cfg_sw_dly), TX_PA (cfg_pa_on_dly) and TX_OFF (cfg_pa_off_dly).
- Decrements while nonzero; saturates at 0.
- A delay of N gives a dwell of N+1 cycles; N = 0 gives 1 cycle.
- cfg_* values are sampled only at entry; changes mid-dwell have no effect.

Invariants (the verification engineer asserts these every cycle):
- txdrv_pwen = 1 implies fe_sel_trx_tx = 1.
- fe_sel_trx_tx and fe_sel_trx_rx are never both 1.
- tx_grant and rx_grant are never both 1.

## Timing

- All outputs are registered, decoded from the next state, so outputs change on the same edge as state. There is no combinational path from any input to any output.
- Request to first output change: 1 cycle.
- Latency from tx_req rising (IDLE) to tx_grant: sw_dly + pa_on_dly + 3 cycles.
- Latency from rx_req rising (IDLE) to rx_grant: sw_dly + 2 cycles.
- Grants fall on the edge after the request deasserts.
- PA-off to switch-release: pa_off_dly + 1 cycles after pwen falls.
- Reset mid-operation: asynchronous. All outputs, state, counter and tx_bursts go to 0 immediately. After reset deasserts, the block restarts from IDLE on the next edge.
- Simultaneous tx_req and rx_req in IDLE: TX_SW.

## Test plan

- Reset values: assert reset mid TX_ON -> every output 0 in the same cycle and state = 0. Release reset with tx_req = 1 -> TX_SW one edge later.
- TX burst: sw = 4, on = 10, off = 6, tx_req held 50 cycles.
  - tx_grant rises 17 cycles after tx_req.
  - pwen is high for exactly the cycles of TX_PA and TX_ON.
  - fe_sel_trx_tx stays high 7 cycles after pwen falls.
  - tx_bursts = 1 afterwards.
- RX port select: cfg_rx_port = 1, sw = 3 -> fe_sel_rx_rx2 = 1 and rx_grant after 5 cycles. Toggling cfg_rx_port during RX_ON does not change the selects.
- Pre-emption: in RX_ON, assert tx_req -> rx_grant falls, fe_sel_trx_tx = 1 on the next edge. Drop tx_req during TX_OFF with rx_req = 1 -> after the off dwell, RX_SW.
- Abort and zero delays: all delays 0, tx_req pulsed 2 cycles -> path TX_SW -> TX_PA -> TX_OFF -> IDLE, pwen high exactly 1 cycle, tx_bursts unchanged.
- Random requests and delays for 100k cycles -> the three invariants hold every cycle. tx_bursts wraps from 0xFFFF to 0 when preloaded by forcing.
